// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: decodes the IR opcode and
// sequences fetch/decode/execute/memory/write-back, stalling on mem_ready.
module multicycle_ctrl #(
    parameter int COUNT_W         = 32,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               ALUSrcA,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               Branch,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic [3:0]         state,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_TRAP   = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_e               state_q, state_d;
    logic                 illegal_q, illegal_d;
    logic [COUNT_W-1:0]   count_q, count_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        count_d   = count_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                    count_d = count_q + COUNT_W'(1);
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:      state_d = S_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_ADDI:       state_d = S_ADDIEX;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = HALT_ON_ILLEGAL ? S_TRAP : S_FETCH;
                    end
                endcase
            end
            // The IR holds the opcode stable, so lw/sw is re-decoded here.
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_RWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    // Controls are forced low while reset is asserted, including the FETCH decode.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        Branch      = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        if (rst) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE: ALUSrcB = 2'b11;
                S_MEMADR, S_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_RWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    Branch      = 1'b1;
                    PCSource    = 2'b01;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                S_ADDIWB: RegWrite = 1'b1;
                default: ;
            endcase
        end
    end

    assign state       = state_q;
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: instruction traces are derived from the
// opcode/stall rules and compared cycle by cycle against both parameterisations.
module tb_multicycle_ctrl;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    logic clk, rst, rst_b, mem_ready;
    logic [5:0] opcode;

    logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, ALUSrcA;
    logic MemtoReg, RegWrite, RegDst, Branch;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
    logic illegal;
    logic [3:0] instr_count;
    logic [16:0] ctrl;

    logic PCWrite_b, PCWriteCond_b, IorD_b, MemRead_b, MemWrite_b, IRWrite_b, ALUSrcA_b;
    logic MemtoReg_b, RegWrite_b, RegDst_b, Branch_b;
    logic [1:0] ALUSrcB_b, ALUOp_b, PCSource_b;
    logic [3:0] state_b;
    logic illegal_b;
    logic [31:0] instr_count_b;
    logic [16:0] ctrl_b;

    int total = 0;
    int bad = 0;
    logic [3:0]  cnt_m;
    logic        ill_m;
    logic [31:0] cnt2;
    logic        ill2;
    int tr_st[$];
    bit tr_mr[$];

    multicycle_ctrl #(.COUNT_W(4), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .RegDst(RegDst), .Branch(Branch), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSource(PCSource), .state(state), .illegal(illegal),
        .instr_count(instr_count)
    );

    multicycle_ctrl #(.COUNT_W(32), .HALT_ON_ILLEGAL(1'b0)) dut_skip (
        .clk(clk), .rst(rst_b), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite_b), .PCWriteCond(PCWriteCond_b), .IorD(IorD_b), .MemRead(MemRead_b),
        .MemWrite(MemWrite_b), .IRWrite(IRWrite_b), .ALUSrcA(ALUSrcA_b), .MemtoReg(MemtoReg_b),
        .RegWrite(RegWrite_b), .RegDst(RegDst_b), .Branch(Branch_b), .ALUSrcB(ALUSrcB_b),
        .ALUOp(ALUOp_b), .PCSource(PCSource_b), .state(state_b), .illegal(illegal_b),
        .instr_count(instr_count_b)
    );

    assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, ALUSrcA,
                   MemtoReg, RegWrite, RegDst, Branch, ALUSrcB, ALUOp, PCSource};
    assign ctrl_b = {PCWrite_b, PCWriteCond_b, IorD_b, MemRead_b, MemWrite_b, IRWrite_b,
                     ALUSrcA_b, MemtoReg_b, RegWrite_b, RegDst_b, Branch_b, ALUSrcB_b,
                     ALUOp_b, PCSource_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control table per state, written straight from the output list.
    function automatic logic [16:0] exp_ctrl(input int st, input bit mr);
        logic pcw, pcwc, iord, mrd, mwr, irw, asa, m2r, rw, rd, br;
        logic [1:0] asb, aop, pcs;
        {pcw, pcwc, iord, mrd, mwr, irw, asa, m2r, rw, rd, br} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            1:  asb = 2'b11;
            2, 10: begin asa = 1; asb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8:  begin asa = 1; aop = 2'b01; pcwc = 1; br = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, asa, m2r, rw, rd, br, asb, aop, pcs};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    endfunction

    function automatic logic [5:0] rand_illegal();
        logic [5:0] op;
        do op = 6'($urandom_range(0, 63)); while (is_legal(op));
        return op;
    endfunction

    function automatic logic [5:0] rand_legal();
        case ($urandom_range(0, 5))
            0: return OP_R;
            1: return OP_LW;
            2: return OP_SW;
            3: return OP_BEQ;
            4: return OP_J;
            default: return OP_ADDI;
        endcase
    endfunction

    // Expected (state, mem_ready) sequence of one instruction; illegal ops end after DECODE.
    task automatic build_trace(input logic [5:0] op, input int fs, input int ms);
        tr_st.delete();
        tr_mr.delete();
        repeat (fs) begin tr_st.push_back(0); tr_mr.push_back(1'b0); end
        tr_st.push_back(0); tr_mr.push_back(1'b1);
        tr_st.push_back(1); tr_mr.push_back(1'($urandom));
        case (op)
            OP_R: begin
                tr_st.push_back(6); tr_mr.push_back(1'($urandom));
                tr_st.push_back(7); tr_mr.push_back(1'($urandom));
            end
            OP_LW: begin
                tr_st.push_back(2); tr_mr.push_back(1'($urandom));
                repeat (ms) begin tr_st.push_back(3); tr_mr.push_back(1'b0); end
                tr_st.push_back(3); tr_mr.push_back(1'b1);
                tr_st.push_back(4); tr_mr.push_back(1'($urandom));
            end
            OP_SW: begin
                tr_st.push_back(2); tr_mr.push_back(1'($urandom));
                repeat (ms) begin tr_st.push_back(5); tr_mr.push_back(1'b0); end
                tr_st.push_back(5); tr_mr.push_back(1'b1);
            end
            OP_BEQ: begin tr_st.push_back(8); tr_mr.push_back(1'($urandom)); end
            OP_J:   begin tr_st.push_back(9); tr_mr.push_back(1'($urandom)); end
            OP_ADDI: begin
                tr_st.push_back(10); tr_mr.push_back(1'($urandom));
                tr_st.push_back(11); tr_mr.push_back(1'($urandom));
            end
            default: ;
        endcase
    endtask

    // Drives one instruction on the main instance, dropping the last 'cut' cycles.
    task automatic run_instr(input string name, input logic [5:0] op, input int fs,
                             input int ms, input int cut);
        build_trace(op, fs, ms);
        for (int i = 0; i < tr_st.size() - cut; i++) begin
            @(negedge clk);
            opcode = op;
            mem_ready = tr_mr[i];
            #2;
            total++;
            if (state !== 4'(tr_st[i]) || ctrl !== exp_ctrl(tr_st[i], tr_mr[i]) ||
                instr_count !== cnt_m || illegal !== ill_m) begin
                bad++;
                $display("FAIL %s cyc=%0d got st=%0d ctrl=%h cnt=%0d ill=%b exp st=%0d ctrl=%h cnt=%0d ill=%b",
                         name, i, state, ctrl, instr_count, illegal,
                         tr_st[i], exp_ctrl(tr_st[i], tr_mr[i]), cnt_m, ill_m);
            end
            if (tr_st[i] == 0 && tr_mr[i]) cnt_m++;
            if (tr_st[i] == 1 && !is_legal(op)) ill_m = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cnt_m = '0;
        ill_m = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mem_ready = 1'b1;
        opcode = OP_R;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #2;
            total++;
            if (state !== 4'd0 || ctrl !== 17'd0 || instr_count !== 4'd0 || illegal !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got st=%0d ctrl=%h cnt=%0d ill=%b exp 0", i,
                         state, ctrl, instr_count, illegal);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #2;
        total++;
        if (state !== 4'd0 || ctrl !== exp_ctrl(0, 1'b1)) begin
            bad++;
            $display("FAIL reset_release got st=%0d ctrl=%h exp st=0 ctrl=%h", state, ctrl,
                     exp_ctrl(0, 1'b1));
        end
        @(negedge clk);
        #2;
        total++;
        if (state !== 4'd1 || instr_count !== 4'd1) begin
            bad++;
            $display("FAIL reset_first_fetch got st=%0d cnt=%0d exp st=1 cnt=1", state, instr_count);
        end
    endtask

    task automatic test_mix();
        do_reset();
        run_instr("mix_r",    OP_R,    0, 0, 0);
        run_instr("mix_lw",   OP_LW,   0, 0, 0);
        run_instr("mix_sw",   OP_SW,   0, 0, 0);
        run_instr("mix_beq",  OP_BEQ,  0, 0, 0);
        run_instr("mix_j",    OP_J,    0, 0, 0);
        run_instr("mix_addi", OP_ADDI, 0, 0, 0);
        @(negedge clk);
        mem_ready = 1'b0;
        #2;
        total++;
        if (instr_count !== 4'd6 || state !== 4'd0) begin
            bad++;
            $display("FAIL mix_end got st=%0d cnt=%0d exp st=0 cnt=6", state, instr_count);
        end
    endtask

    task automatic test_lw_stall();
        do_reset();
        run_instr("lw_stall", OP_LW, 3, 2, 0);
        @(negedge clk);
        mem_ready = 1'b0;
        #2;
        total++;
        if (instr_count !== 4'd1 || state !== 4'd0) begin
            bad++;
            $display("FAIL lw_stall_end got st=%0d cnt=%0d exp st=0 cnt=1", state, instr_count);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 40; n++)
            run_instr("random", rand_legal(), $urandom_range(0, 3), $urandom_range(0, 3), 0);
    endtask

    task automatic test_illegal_halt();
        do_reset();
        run_instr("ill_fetch", 6'b111111, $urandom_range(0, 2), 0, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom);
            opcode = rand_legal();
            #2;
            total++;
            if (state !== 4'd12 || ctrl !== 17'd0 || illegal !== 1'b1) begin
                bad++;
                $display("FAIL trap_hold cyc=%0d got st=%0d ctrl=%h ill=%b exp st=12 ctrl=0 ill=1",
                         i, state, ctrl, illegal);
            end
        end
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        total++;
        if (state !== 4'd0 || illegal !== 1'b0 || instr_count !== 4'd0 || ctrl !== 17'd0) begin
            bad++;
            $display("FAIL trap_reset got st=%0d ill=%b cnt=%0d ctrl=%h exp all 0", state,
                     illegal, instr_count, ctrl);
        end
    endtask

    task automatic test_illegal_skip();
        logic [5:0] ops[5];
        ops = '{rand_illegal(), OP_ADDI, 6'b111111, OP_J, OP_R};
        @(negedge clk);
        rst = 1'b0;
        rst_b = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        cnt2 = '0;
        ill2 = 1'b0;
        foreach (ops[k]) begin
            build_trace(ops[k], $urandom_range(0, 2), 0);
            for (int i = 0; i < tr_st.size(); i++) begin
                @(negedge clk);
                opcode = ops[k];
                mem_ready = tr_mr[i];
                #2;
                total++;
                if (state_b !== 4'(tr_st[i]) || ctrl_b !== exp_ctrl(tr_st[i], tr_mr[i]) ||
                    instr_count_b !== cnt2 || illegal_b !== ill2) begin
                    bad++;
                    $display("FAIL skip op=%b cyc=%0d got st=%0d ctrl=%h cnt=%0d ill=%b exp st=%0d ctrl=%h cnt=%0d ill=%b",
                             ops[k], i, state_b, ctrl_b, instr_count_b, illegal_b, tr_st[i],
                             exp_ctrl(tr_st[i], tr_mr[i]), cnt2, ill2);
                end
                if (tr_st[i] == 0 && tr_mr[i]) cnt2++;
                if (tr_st[i] == 1 && !is_legal(ops[k])) ill2 = 1'b1;
            end
        end
        @(negedge clk);
        #1 rst_b = 1'b0;
        #1;
        total++;
        if (state_b !== 4'd0 || illegal_b !== 1'b0 || instr_count_b !== 32'd0) begin
            bad++;
            $display("FAIL skip_reset got st=%0d ill=%b cnt=%0d exp all 0", state_b, illegal_b,
                     instr_count_b);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        repeat (17) run_instr("j_wrap", OP_J, 0, 0, 0);
        @(negedge clk);
        mem_ready = 1'b0;
        #2;
        total++;
        if (instr_count !== 4'd1 || state !== 4'd0) begin
            bad++;
            $display("FAIL wrap got st=%0d cnt=%0d exp st=0 cnt=1", state, instr_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_instr("rwb_pre", OP_R, $urandom_range(0, 2), 0, 1);
        @(negedge clk);
        mem_ready = 1'b1;
        #2;
        total++;
        if (state !== 4'd7 || RegWrite !== 1'b1) begin
            bad++;
            $display("FAIL rwb_reach got st=%0d RegWrite=%b exp st=7 RegWrite=1", state, RegWrite);
        end
        #1 rst = 1'b0;
        #1;
        total++;
        if (state !== 4'd0 || RegWrite !== 1'b0 || ctrl !== 17'd0) begin
            bad++;
            $display("FAIL rwb_abort got st=%0d RegWrite=%b ctrl=%h exp st=0 ctrl=0", state,
                     RegWrite, ctrl);
        end
        do_reset();
        run_instr("sw_pre", OP_SW, 1, 3, 2);
        @(negedge clk);
        mem_ready = 1'b0;
        #2;
        total++;
        if (state !== 4'd5 || MemWrite !== 1'b1) begin
            bad++;
            $display("FAIL memwr_reach got st=%0d MemWrite=%b exp st=5 MemWrite=1", state, MemWrite);
        end
        #1 rst = 1'b0;
        #1;
        total++;
        if (state !== 4'd0 || MemWrite !== 1'b0 || ctrl !== 17'd0 || instr_count !== 4'd0) begin
            bad++;
            $display("FAIL memwr_abort got st=%0d MemWrite=%b ctrl=%h cnt=%0d exp 0", state,
                     MemWrite, ctrl, instr_count);
        end
        mem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #2;
            total++;
            if (state !== 4'd0 || ctrl !== 17'd0) begin
                bad++;
                $display("FAIL abort_hold got st=%0d ctrl=%h exp 0", state, ctrl);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        rst_b = 1'b0;
        mem_ready = 1'b1;
        opcode = OP_R;
        cnt_m = '0;
        ill_m = 1'b0;
        cnt2 = '0;
        ill2 = 1'b0;
        test_reset();
        test_mix();
        test_lw_stall();
        test_random();
        test_illegal_halt();
        test_illegal_skip();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
